// File: rtl/stream_fifo_flow_true_has_flush_pkg.sv
// rtl/stream_fifo_flow_true_has_flush_pkg.sv - width helpers shared by the flow-through FIFO
package stream_fifo_flow_true_has_flush_pkg;

   // Pointer width never drops below one bit, even for a single-entry FIFO.
   function automatic int ptr_bits(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   function automatic int cnt_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_flow_storage.sv
// rtl/fifo_flow_storage.sv - circular buffer with pointers, count and synchronous flush
module fifo_flow_storage
   import stream_fifo_flow_true_has_flush_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int PTR_W     = ptr_bits(FIFO_DEPTH),
   localparam int CNT_W     = cnt_bits(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en_i,
   input  logic                  r_en_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] w_data_i,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CNT_W-1:0]      count_o
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // Explicit wrap so non-power-of-two depths return to slot 0.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (w_en_i) wptr_d = ptr_next(wptr_q);
         if (r_en_i) rptr_d = ptr_next(rptr_q);
         case ({w_en_i, r_en_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; stale contents are unreachable once count is zero.
   always_ff @(posedge clk) begin
      if (w_en_i && !flush_i) mem_q[wptr_q] <= w_data_i;
   end

   assign r_data_o = mem_q[rptr_q];
   assign full_o   = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;

endmodule

// File: rtl/stream_fifo_flow_true_has_flush.sv
// rtl/stream_fifo_flow_true_has_flush.sv - zero-latency flow-through stream FIFO with flush
module stream_fifo_flow_true_has_flush
   import stream_fifo_flow_true_has_flush_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int CNT_W     = cnt_bits(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  w_ready_o,
   input  logic                  w_valid_i,
   input  logic [DATA_WIDTH-1:0] w_data_i,
   output logic                  r_valid_o,
   input  logic                  r_ready_i,
   output logic [DATA_WIDTH-1:0] r_data_o,
   input  logic                  flush,
   output logic [CNT_W-1:0]      count_o
);

   logic                  full;
   logic                  empty;
   logic                  flow;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Write readiness deliberately ignores r_ready_i: no same-cycle slot reuse when full.
   assign w_ready_o = rst_n & ~full;
   assign r_valid_o = rst_n & ~flush & (~empty | w_valid_i);

   assign flow = empty & w_valid_i & r_ready_i & ~flush;
   assign push = w_valid_i & w_ready_o & ~flush & ~flow;
   assign pop  = r_ready_i & ~empty & ~flush;

   assign r_data_o = empty ? w_data_i : mem_rdata;

   fifo_flow_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_storage (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_en_i   (push),
      .r_en_i   (pop),
      .flush_i  (flush),
      .w_data_i (w_data_i),
      .r_data_o (mem_rdata),
      .full_o   (full),
      .empty_o  (empty),
      .count_o  (count_o)
   );

endmodule

// File: tb/tb_stream_fifo_flow_true_has_flush.sv
// tb/tb_stream_fifo_flow_true_has_flush.sv - directed self-checking bench for the flow-through FIFO
module tb_stream_fifo_flow_true_has_flush;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A: depth 4
   logic        rst_a, wv_a, rr_a, fl_a, wr_a, rv_a;
   logic [31:0] wd_a, rd_a;
   logic [2:0]  cnt_a;

   // Instance B: depth 3
   logic        rst_b, wv_b, rr_b, fl_b, wr_b, rv_b;
   logic [31:0] wd_b, rd_b;
   logic [1:0]  cnt_b;

   stream_fifo_flow_true_has_flush #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_a), .w_ready_o(wr_a), .w_valid_i(wv_a), .w_data_i(wd_a),
      .r_valid_o(rv_a), .r_ready_i(rr_a), .r_data_o(rd_a), .flush(fl_a), .count_o(cnt_a)
   );

   stream_fifo_flow_true_has_flush #(.DATA_WIDTH(32), .FIFO_DEPTH(3)) dut_b (
      .clk(clk), .rst_n(rst_b), .w_ready_o(wr_b), .w_valid_i(wv_b), .w_data_i(wd_b),
      .r_valid_o(rv_b), .r_ready_i(rr_b), .r_data_o(rd_b), .flush(fl_b), .count_o(cnt_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] q[$];
      int          sent;
      int          k;
      logic        exp_wr;

      rst_a = 0; wv_a = 1; rr_a = 0; fl_a = 0; wd_a = 32'h99;
      rst_b = 0; wv_b = 0; rr_b = 0; fl_b = 0; wd_b = 0;
      tick(); tick();
      check_eq("rst_wready", 32'(wr_a), 0);
      check_eq("rst_rvalid", 32'(rv_a), 0);
      rst_a = 1; wv_a = 0;
      tick();
      check_eq("post_rst_count", 32'(cnt_a), 0);
      check_eq("post_rst_wready", 32'(wr_a), 1);
      check_eq("post_rst_rvalid", 32'(rv_a), 0);

      // Flow-through
      wv_a = 1; wd_a = 32'hA5; rr_a = 1;
      #1;
      check_eq("flow_rvalid", 32'(rv_a), 1);
      check_eq("flow_rdata", rd_a, 32'hA5);
      tick();
      wv_a = 0;
      #1;
      check_eq("flow_count", 32'(cnt_a), 0);
      check_eq("flow_rvalid_after", 32'(rv_a), 0);

      // Fill to full
      rr_a = 0;
      for (int i = 1; i <= 4; i++) begin
         wv_a = 1; wd_a = 32'(i);
         #1;
         check_eq("fill_wready", 32'(wr_a), 1);
         if (i == 1) check_eq("fill_first_bypass", rd_a, 32'h1);
         tick();
      end
      check_eq("full_count", 32'(cnt_a), 4);
      check_eq("full_wready", 32'(wr_a), 0);
      wd_a = 32'h5;
      tick();
      check_eq("full_reject_count", 32'(cnt_a), 4);
      check_eq("full_head", rd_a, 32'h1);
      wv_a = 0; rr_a = 1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check_eq("drain_rvalid", 32'(rv_a), 1);
         check_eq("drain_rdata", rd_a, 32'(i));
         tick();
         check_eq("drain_count", 32'(cnt_a), 32'(4 - i));
         if (i == 1) check_eq("drain_wready", 32'(wr_a), 1);
      end

      // Streaming with count held at 2, pointers wrapping
      rr_a = 0; wv_a = 1;
      wd_a = 32'h10; tick();
      wd_a = 32'h11; tick();
      check_eq("stream_prefill", 32'(cnt_a), 2);
      rr_a = 1;
      for (int i = 0; i < 8; i++) begin
         wd_a = 32'h12 + 32'(i);
         #1;
         check_eq("stream_rdata", rd_a, 32'h10 + 32'(i));
         tick();
         check_eq("stream_count", 32'(cnt_a), 2);
      end
      wv_a = 0;
      check_eq("stream_tail0", rd_a, 32'h18); tick();
      check_eq("stream_tail1", rd_a, 32'h19); tick();
      check_eq("stream_empty", 32'(cnt_a), 0);

      // Flush with count 3 and a write in the flush cycle
      rr_a = 0; wv_a = 1;
      wd_a = 32'h20; tick();
      wd_a = 32'h21; tick();
      wd_a = 32'h22; tick();
      check_eq("flush_pre_count", 32'(cnt_a), 3);
      fl_a = 1; wd_a = 32'hDEAD; rr_a = 1;
      #1;
      check_eq("flush_rvalid", 32'(rv_a), 0);
      tick();
      fl_a = 0; wv_a = 0; rr_a = 0;
      #1;
      check_eq("flush_count", 32'(cnt_a), 0);
      check_eq("flush_rvalid_after", 32'(rv_a), 0);
      wv_a = 1; wd_a = 32'h30;
      tick();
      wv_a = 0;
      #1;
      check_eq("post_flush_count", 32'(cnt_a), 1);
      check_eq("post_flush_rdata", rd_a, 32'h30);
      rr_a = 1; tick(); rr_a = 0;
      check_eq("post_flush_drain", 32'(cnt_a), 0);

      // Reset mid-stream
      wv_a = 1;
      wd_a = 32'h40; tick();
      wd_a = 32'h41; tick();
      check_eq("midrst_pre_count", 32'(cnt_a), 2);
      rst_a = 0;
      #1;
      check_eq("midrst_wready", 32'(wr_a), 0);
      check_eq("midrst_rvalid", 32'(rv_a), 0);
      tick();
      check_eq("midrst_rvalid_held", 32'(rv_a), 0);
      rst_a = 1; wv_a = 0;
      tick();
      check_eq("midrst_count", 32'(cnt_a), 0);
      check_eq("midrst_wready_after", 32'(wr_a), 1);

      // Depth 3: seven beats with alternating read stalls
      rst_b = 1;
      tick();
      sent = 0;
      k = 0;
      while (sent < 7 && k < 40) begin
         wv_b = 1; wd_b = 32'h50 + 32'(sent); rr_b = k[0];
         exp_wr = (q.size() < 3);
         #1;
         check_eq("d3_rvalid", 32'(rv_b), 1);
         check_eq("d3_rdata", rd_b, (q.size() != 0) ? q[0] : wd_b);
         check_eq("d3_wready", 32'(wr_b), 32'(exp_wr));
         check_eq("d3_count", 32'(cnt_b), 32'(q.size()));
         if (q.size() == 0 && rr_b) begin
            sent++;
         end else begin
            if (rr_b && q.size() != 0) void'(q.pop_front());
            if (exp_wr) begin
               q.push_back(wd_b);
               sent++;
            end
         end
         tick();
         k++;
      end
      check_eq("d3_all_sent", 32'(sent), 7);
      wv_b = 0; rr_b = 1;
      k = 0;
      while (q.size() != 0 && k < 10) begin
         #1;
         check_eq("d3_drain_rdata", rd_b, q[0]);
         void'(q.pop_front());
         tick();
         k++;
      end
      check_eq("d3_final_count", 32'(cnt_b), 0);
      check_eq("d3_final_rvalid", 32'(rv_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
